router_fifo_pkt: RTL

Parametrised, packet-aware synchronous FIFO, the next generation of the per-destination router output buffer. Stores each byte with a header tag and tracks packet boundaries on the read side using the header length field. Adds occupancy count, almost-full/almost-empty flags, registered read with valid strobe, overflow/underflow pulses and end-of-packet indication. Sits between the router FSM/register write path and each output port's read interface.

---
 rtl/router_fifo_pkt_pkg.sv | 25 ++
 rtl/router_fifo_pkt_if.sv | 39 +++
 rtl/router_fifo_pkt_tracker.sv | 37 +++
 rtl/router_fifo_pkt.sv | 103 ++++++++++
 4 files changed

// File: rtl/router_fifo_pkt_pkg.sv
// Shared defaults and helpers for the packet-aware router FIFO.
// Provides pointer-width and header length-field extraction functions.
package router_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_LEN_LSB    = 2;
  localparam int DEF_LEN_W      = 6;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Caller truncates the result to its own field width.
  function automatic logic [31:0] hdr_field(
    input logic [63:0] w,
    input int          lsb,
    input int          width
  );
    logic [63:0] v;
    v = (w >> lsb) & ((64'd1 << width) - 64'd1);
    return v[31:0];
  endfunction

endpackage

// File: rtl/router_fifo_pkt_if.sv
// Write/read bundle of the router FIFO: write_enb/lfd_state/data_in in,
// registered read data, packet, occupancy and error flags out.
interface router_fifo_pkt_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  write_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  header_out;
  logic                  pkt_done;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, data_valid, header_out, pkt_done,
    output full, empty, almost_full, almost_empty,
    output count, overflow, underflow
  );

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, data_valid, header_out, pkt_done,
    input  full, empty, almost_full, almost_empty,
    input  count, overflow, underflow
  );

endinterface

// File: rtl/router_fifo_pkt_tracker.sv
// Packet boundary tracker: loads length+1 on a header read, counts down
// on payload reads, pulses o_pkt_done with the read that reaches zero.
module router_fifo_pkt_tracker #(
  parameter int LEN_W = 6
) (
  input  logic             clock,
  input  logic             i_flush,
  input  logic             i_rd_acc,
  input  logic             i_tag,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_pkt_done
);

  logic [LEN_W:0] r_pkt_cnt;
  logic           r_pkt_done;

  always_ff @(posedge clock) begin
    if (i_flush) begin
      r_pkt_cnt  <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (i_rd_acc) begin
        if (i_tag) begin
          // Header reload also covers a truncated packet.
          r_pkt_cnt <= {1'b0, i_len} + (LEN_W+1)'(1);
        end else if (r_pkt_cnt != '0) begin
          r_pkt_cnt  <= r_pkt_cnt - (LEN_W+1)'(1);
          r_pkt_done <= (r_pkt_cnt == (LEN_W+1)'(1));
        end
      end
    end
  end

  assign o_pkt_done = r_pkt_done;

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware synchronous FIFO for one router output port.
// Ports: clock, reset, soft_reset (flush), bus (router_fifo_pkt_if.slave).
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_LSB    = DEF_LEN_LSB,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int AF_TH      = DEPTH - 2,
  parameter int AE_TH      = 2
) (
  input logic               clock,
  input logic               reset,
  input logic               soft_reset,
  router_fifo_pkt_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_header_out;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_flush;
  logic                  w_empty;
  logic                  w_full;
  logic [PW-1:0]         w_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH:0]   w_rd_word;
  logic [LEN_W-1:0]      w_len;

  assign w_flush  = reset | soft_reset;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_wr_acc = bus.write_enb && !w_full;
  assign w_rd_acc = bus.read_enb && !w_empty;

  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
  assign w_len     = LEN_W'(hdr_field(64'(w_rd_word[DATA_WIDTH-1:0]),
                                      LEN_LSB, LEN_W));

  // Storage is never cleared; flushed contents are unreachable.
  always_ff @(posedge clock) begin
    if (w_wr_acc && !w_flush)
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_header_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      r_overflow   <= bus.write_enb && w_full;
      r_underflow  <= bus.read_enb && w_empty;
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_data_out   <= w_rd_word[DATA_WIDTH-1:0];
        r_header_out <= w_rd_word[DATA_WIDTH];
      end
    end
  end

  router_fifo_pkt_tracker #(
    .LEN_W (LEN_W)
  ) u_trk (
    .clock      (clock),
    .i_flush    (w_flush),
    .i_rd_acc   (w_rd_acc),
    .i_tag      (w_rd_word[DATA_WIDTH]),
    .i_len      (w_len),
    .o_pkt_done (bus.pkt_done)
  );

  assign bus.data_out     = r_data_out;
  assign bus.data_valid   = r_data_valid;
  assign bus.header_out   = r_header_out;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.count        = w_count;
  assign bus.almost_full  = (w_count >= PW'(AF_TH));
  assign bus.almost_empty = (w_count <= PW'(AE_TH));
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
